// File: rtl/iq_decimator.sv
// Complex (I/Q) decimator by RATIO with runtime-selectable pick / average modes.
// Optional feature macro: IQ_DECIM_ROUND_EN (round half up in average mode;
// floor when undefined).
module iq_decimator #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RATIO  = 32,
  parameter int unsigned PHASE  = 0,
  parameter int unsigned CNT_W  = $clog2(RATIO)
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic [CNT_W-1:0]         frame_phase
);

  localparam int unsigned ACC_W = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] PickCnt = CNT_W'(PHASE);

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     mode_q, mode_d;
  logic signed [ACC_W-1:0]  acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic                     valid_q, valid_d;
  logic signed [DATA_W-1:0] out_r_q, out_r_d, out_i_q, out_i_d;

  logic                     frame_start, frame_last, mode_eff;
  logic signed [ACC_W-1:0]  ext_r, ext_i, sum_r, sum_i, fin_r, fin_i;
  logic                     unused_lsb;

  // Frame decode, sign extension, running sums and the scaled average
  always_comb begin
    frame_start = (cnt_q == '0);
    frame_last  = (cnt_q == LastCnt);
    // The first sample of a frame already uses the freshly selected mode
    mode_eff    = frame_start ? mode : mode_q;
    ext_r       = {{CNT_W{in_real[DATA_W-1]}}, in_real};
    ext_i       = {{CNT_W{in_imag[DATA_W-1]}}, in_imag};
    sum_r       = frame_start ? ext_r : acc_r_q + ext_r;
    sum_i       = frame_start ? ext_i : acc_i_q + ext_i;
`ifdef IQ_DECIM_ROUND_EN
    fin_r       = sum_r + (ACC_W'(1) << (CNT_W - 1));
    fin_i       = sum_i + (ACC_W'(1) << (CNT_W - 1));
`else
    fin_r       = sum_r;
    fin_i       = sum_i;
`endif
  end

  // Bits below the binary point are dropped by the divide-by-RATIO slice
  assign unused_lsb = ^{fin_r[CNT_W-1:0], fin_i[CNT_W-1:0]};

  // Next-state: clear wins over in_valid; idle cycles only drop the strobe
  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    valid_d = 1'b0;
    out_r_d = out_r_q;
    out_i_d = out_i_q;
    if (clear) begin
      cnt_d   = '0;
      mode_d  = mode;
      acc_r_d = '0;
      acc_i_d = '0;
    end else if (in_valid) begin
      cnt_d   = frame_last ? '0 : cnt_q + CNT_W'(1);
      mode_d  = mode_eff;
      acc_r_d = sum_r;
      acc_i_d = sum_i;
      if (!mode_eff && (cnt_q == PickCnt)) begin
        valid_d = 1'b1;
        out_r_d = in_real;
        out_i_d = in_imag;
      end else if (mode_eff && frame_last) begin
        // Slice at CNT_W is the arithmetic shift by CNT_W, low DATA_W bits
        valid_d = 1'b1;
        out_r_d = fin_r[CNT_W +: DATA_W];
        out_i_d = fin_i[CNT_W +: DATA_W];
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      acc_r_q <= '0;
      acc_i_q <= '0;
      valid_q <= 1'b0;
      out_r_q <= '0;
      out_i_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
      valid_q <= valid_d;
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_real    = out_r_q;
  assign out_imag    = out_i_q;
  assign frame_phase = cnt_q;

endmodule
